// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-save adder.
package csa_pkg;

   localparam int unsigned CSA_DEFAULT_N = 4;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/csa_cell.sv
// One-bit full-adder cell: purely combinational sum and carry-out.
module csa_cell
   import csa_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = maj3(a, b, c);

endmodule

// File: rtl/csa.sv
// Registered N-bit carry-save adder. Define CSA_TOTAL_EN to add a registered
// carry-propagate stage that resolves the full sum on the total port.
module csa
   import csa_pkg::*;
#(
   parameter int unsigned N = CSA_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic         out_valid,
   output logic [N-1:0] sum,
`ifdef CSA_TOTAL_EN
   output logic [N-1:0] carry,
   output logic [N+1:0] total
`else
   output logic [N-1:0] carry
`endif
);

   logic [N-1:0] w_sum;
   logic [N-1:0] w_carry;
   logic         r_valid;
   logic [N-1:0] r_sum;
   logic [N-1:0] r_carry;

   for (genvar i = 0; i < N; i++) begin : g_cell
      csa_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .c  (c[i]),
         .s  (w_sum[i]),
         .co (w_carry[i])
      );
   end

   // Results only update on valid edges; invalid edges hold the last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_carry <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
         end
      end
   end

   assign out_valid = r_valid;
   assign sum       = r_sum;
   assign carry     = r_carry;

`ifdef CSA_TOTAL_EN
   logic [N+1:0] w_total;
   logic [N+1:0] r_total;

   // Carry vector carries weight 2^(i+1), hence the one-bit left shift.
   assign w_total = {2'b00, w_sum} + {1'b0, w_carry, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_total <= '0;
      end else if (in_valid) begin
         r_total <= w_total;
      end
   end

   assign total = r_total;
`endif

endmodule

// File: tb/tb_csa.sv
// Directed checks of csa at N=4 plus a random invariant sweep at N=8.
module tb_csa;

   logic       clk;
   logic       rst_n;
   logic       v4;
   logic [3:0] a4, b4, c4;
   logic       ov4;
   logic [3:0] s4, cy4;
   logic       v8;
   logic [7:0] a8, b8, c8;
   logic       ov8;
   logic [7:0] s8, cy8;
`ifdef CSA_TOTAL_EN
   logic [5:0] t4;
   logic [9:0] t8;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   csa #(.N(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v4),
      .a         (a4),
      .b         (b4),
      .c         (c4),
      .out_valid (ov4),
      .sum       (s4),
`ifdef CSA_TOTAL_EN
      .carry     (cy4),
      .total     (t4)
`else
      .carry     (cy4)
`endif
   );

   csa #(.N(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v8),
      .a         (a8),
      .b         (b8),
      .c         (c8),
      .out_valid (ov8),
      .sum       (s8),
`ifdef CSA_TOTAL_EN
      .carry     (cy8),
      .total     (t8)
`else
      .carry     (cy8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic apply4(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
      @(negedge clk);
      v4 = v;
      a4 = a;
      b4 = b;
      c4 = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect4(input string tag, input logic v, input logic [3:0] s,
                          input logic [3:0] cy, input logic [5:0] t);
      check({tag, "_valid"}, 64'(ov4), 64'(v));
      check({tag, "_sum"}, 64'(s4), 64'(s));
      check({tag, "_carry"}, 64'(cy4), 64'(cy));
`ifdef CSA_TOTAL_EN
      check({tag, "_total"}, 64'(t4), 64'(t));
`else
      if (t != t) $display("unreachable");
`endif
   endtask

   initial begin
      logic [63:0] got, exp;
      rst_n = 1'b0;
      v4 = 1'b0; a4 = '0; b4 = '0; c4 = '0;
      v8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
      #12;
      expect4("reset", 1'b0, 4'h0, 4'h0, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;

      apply4(1'b1, 4'b1010, 4'b1100, 4'b0110);
      expect4("vec27", 1'b1, 4'b0000, 4'b1110, 6'd28);
      apply4(1'b1, 4'b1111, 4'b1111, 4'b1111);
      expect4("max", 1'b1, 4'b1111, 4'b1111, 6'd45);
      apply4(1'b1, 4'b0000, 4'b0000, 4'b0000);
      expect4("zero", 1'b1, 4'b0000, 4'b0000, 6'd0);

      apply4(1'b1, 4'b1001, 4'b0101, 4'b0011);
      expect4("b2b_1", 1'b1, 4'b1111, 4'b0001, 6'd17);
      apply4(1'b1, 4'b0111, 4'b1010, 4'b1100);
      expect4("b2b_2", 1'b1, 4'b0001, 4'b1110, 6'd29);

      // Idle edge with junk operands: outputs must hold, valid must drop.
      apply4(1'b0, 4'b1111, 4'b0000, 4'b1111);
      expect4("hold", 1'b0, 4'b0001, 4'b1110, 6'd29);

      // Asynchronous reset between edges while a result is presented.
      apply4(1'b1, 4'b1010, 4'b1100, 4'b0110);
      expect4("pre_rst", 1'b1, 4'b0000, 4'b1110, 6'd28);
      apply4(1'b1, 4'b1111, 4'b1111, 4'b1111);
      rst_n = 1'b0;
      #1;
      expect4("async_rst", 1'b0, 4'h0, 4'h0, 6'd0);
      @(negedge clk);
      v4 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect4("post_rst_idle", 1'b0, 4'h0, 4'h0, 6'd0);
      apply4(1'b1, 4'b0011, 4'b0101, 4'b0110);
      expect4("first_after_rst", 1'b1, 4'b0000, 4'b0111, 6'd14);
      apply4(1'b0, 4'b0000, 4'b0000, 4'b0000);

      // Random sweep on the 8-bit instance, checked against a bench model.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         v8 = 1'b1;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 8'($urandom);
         @(posedge clk);
         #1;
         got = 64'(s8) + (64'(cy8) << 1);
         exp = 64'(a8) + 64'(b8) + 64'(c8);
         check("rand_invariant", got, exp);
         check("rand_sum", 64'(s8), 64'(a8 ^ b8 ^ c8));
         check("rand_valid", 64'(ov8), 64'd1);
`ifdef CSA_TOTAL_EN
         check("rand_total", 64'(t8), exp);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
